// File: rtl/cskipa_16b_arbiter.sv
// Round-robin arbiter sharing one carry-skip 16-bit adder among NREQ requesters.
// Optional exact-sum checker enabled by defining CSKIPA_ARB_CHECK_EN.

module CSkipA_16b (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_s,
    output logic        o_cout
);
    logic [4:0] w_c;

    assign w_c[0] = i_cin;
    assign o_cout = w_c[4];

    for (genvar g = 0; g < 4; g++) begin : g_blk
        logic [3:0] w_ba;
        logic [3:0] w_bb;
        logic [3:0] w_s;
        logic [4:0] w_rc;
        logic       w_p;

        assign w_ba = i_a[4*g +: 4];
        assign w_bb = i_b[4*g +: 4];
        assign w_p  = &(w_ba ^ w_bb);

        always_comb begin
            w_rc[0] = w_c[g];
            w_s     = '0;
            for (int j = 0; j < 4; j++) begin
                w_s[j]    = w_ba[j] ^ w_bb[j] ^ w_rc[j];
                w_rc[j+1] = (w_ba[j] & w_bb[j]) | (w_rc[j] & (w_ba[j] ^ w_bb[j]));
            end
        end

        // When every bit propagates, the block carry-in bypasses the ripple chain.
        assign w_c[g+1]       = w_p ? w_c[g] : w_rc[4];
        assign o_s[4*g +: 4]  = w_s;
    end
endmodule

module cskipa_16b_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*16-1:0] req_a,
    input  logic [NREQ*16-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [16:0]        rsp_sum,
    output logic [ID_W-1:0]    rsp_id,
    output logic               rsp_err,
    output logic [15:0]        err_count
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ID_W-1:0] r_ptr;
    logic [16:0]     r_sum;
    logic [ID_W-1:0] r_id;
    logic            w_found;
    logic [ID_W-1:0] w_gnt;
    logic            w_can_accept;
    logic            w_xfer;
    logic [15:0]     w_a;
    logic [15:0]     w_b;
    logic [15:0]     w_s;
    logic            w_cout;
    logic [16:0]     w_sum;
    logic [ID_W-1:0] w_ptr_nxt;

    always_comb begin
        int v_idx;
        w_found = 1'b0;
        w_gnt   = '0;
        v_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && req_valid[v_idx]) begin
                w_found = 1'b1;
                w_gnt   = v_idx[ID_W-1:0];
            end
        end
    end

    assign w_can_accept = (r_state == EMPTY) || rsp_ready;

    always_comb begin
        req_ready = '0;
        if (w_found && w_can_accept && !rst)
            req_ready[w_gnt] = 1'b1;
    end

    assign w_xfer = |(req_valid & req_ready);

    assign w_a = req_a[{w_gnt, 4'b0000} +: 16];
    assign w_b = req_b[{w_gnt, 4'b0000} +: 16];

    CSkipA_16b u_add (
        .i_a    (w_a),
        .i_b    (w_b),
        .i_cin  (1'b0),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    assign w_sum     = {w_cout, w_s};
    assign w_ptr_nxt = (w_gnt == ID_W'(NREQ - 1)) ? '0 : w_gnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            EMPTY: if (w_xfer) w_state_nxt = FULL;
            FULL:  if (rsp_ready && !w_xfer) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_ptr   <= '0;
            r_sum   <= '0;
            r_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_ptr <= w_ptr_nxt;
                r_sum <= w_sum;
                r_id  <= w_gnt;
            end
        end
    end

    assign rsp_valid = (r_state == FULL);
    assign rsp_sum   = r_sum;
    assign rsp_id    = r_id;

`ifdef CSKIPA_ARB_CHECK_EN
    logic [16:0] w_exact;
    logic        w_mis;
    logic        r_err;
    logic [15:0] r_err_cnt;

    assign w_exact = {1'b0, w_a} + {1'b0, w_b};
    assign w_mis   = (w_exact != w_sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_xfer) begin
            r_err <= w_mis;
            if (w_mis && r_err_cnt != 16'hFFFF)
                r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign rsp_err   = r_err;
    assign err_count = r_err_cnt;
`else
    assign rsp_err   = 1'b0;
    assign err_count = 16'h0000;
`endif
endmodule

// File: doc/cskipa_16b_arbiter.md
# cskipa_16b_arbiter

- Shares one combinational `CSkipA_16b` adder instance among `NREQ` requesters.
- Each requester presents two 16-bit operands under a valid/ready handshake. The block grants one request per cycle in round-robin order, feeds it through the shared adder, and registers the 17-bit result `{Cout,S}` with the requester's ID into a single-entry output stage.
- It sits between operand sources (pattern generators, accumulator loops) and the approximate-adder datapath. The same shared adder can therefore be characterised under contention without duplicating it.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default 2: width of `rsp_id`; must equal clog2(`NREQ`).

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input `NREQ`: per-requester request valid.
- `req_ready` output `NREQ`: per-requester accept (combinational, one-hot or zero).
- `req_a` input `NREQ*16`: operand A; requester i occupies bits [16i+15:16i].
- `req_b` input `NREQ*16`: operand B; same packing as `req_a`.
- `rsp_valid` output 1: result register holds a valid result.
- `rsp_ready` input 1: downstream accepts the result.
- `rsp_sum` output 17: `{Cout,S}` from the shared adder.
- `rsp_id` output `ID_W`: index of the requester that produced `rsp_sum`.
- `rsp_err` output 1: result differs from the exact sum (only with `CSKIPA_ARB_CHECK_EN`).
- `err_count` output 16: saturating mismatch count (only with `CSKIPA_ARB_CHECK_EN`).

## Operation
- Two states:
  - EMPTY (`rsp_valid`=0).
  - FULL (`rsp_valid`=1).
- `can_accept` = EMPTY, or FULL with `rsp_ready`=1 (drain and refill in the same cycle).
- Round-robin pointer `ptr`, reset to 0:
  - Grant goes to the first i with `req_valid[i]`=1, searching `ptr`, `ptr+1`, …, wrapping modulo `NREQ`.
  - `req_ready[i]`=1 only for the granted i, only when `can_accept`=1 and `rst`=0.
- Transfer occurs when `req_valid[i]` and `req_ready[i]` are both 1. On transfer:
  - Operands of i are muxed into the adder.
  - `{Cout,S}` is captured into `rsp_sum`, and i into `rsp_id`.
  - `rsp_valid` is set, and `ptr` becomes (i+1) mod `NREQ`.
- No transfer in a cycle leaves `ptr` unchanged.
- FULL with `rsp_ready`=1 and no transfer: go to EMPTY; `rsp_sum` and `rsp_id` keep their last value.
- FULL with `rsp_ready`=0: all `req_ready`=0; `rsp_sum`, `rsp_id` and `rsp_err` are held stable.
- Requester obligations: hold `req_valid` and its operands stable until accepted. A non-granted requester is never dropped.
- Arithmetic:
  - `rsp_sum` is exactly the adder's output, approximate or not.
  - No truncation; bit 16 is `Cout`.

## Timing
- Reset values: `rsp_valid`=0, `rsp_sum`=0, `rsp_id`=0, `rsp_err`=0, `err_count`=0, `ptr`=0. `req_ready`=0 while `rst`=1.
- Latency: request accepted at edge t gives `rsp_valid`=1 after edge t (visible in cycle t+1).
- Throughput: one result per cycle while `rsp_ready` stays 1.
- Fairness: a continuously asserting requester waits at most `NREQ`−1 grants.
- Reset mid-operation: a pending result is discarded and the pointer returns to 0. A request presented in the reset cycle is not accepted.
- Combinational paths:
  - `req_valid` → `req_ready`.
  - `rsp_ready` → `req_ready`.
  - Adder path: `req_a`/`req_b` → `rsp_sum` register D input.
  - No path from `req_*` to `rsp_*` outputs without a register.

## Configuration
- `CSKIPA_ARB_CHECK_EN` defined:
  - On each transfer, the exact 17-bit sum A+B is computed behaviourally and compared with `{Cout,S}`.
  - `rsp_err` registers the mismatch alongside `rsp_sum`.
  - `err_count` increments by 1 per mismatching transfer and saturates at 16'hFFFF.
- Not defined:
  - No comparator is synthesised.
  - `rsp_err` and `err_count` are tied to 0; the ports remain present.

## Test plan
- **Reset:** assert `rst` with all `req_valid`=1 → `req_ready`=0; after release, `rsp_valid`=0, `rsp_sum`=0, `err_count`=0.
- **Single request:** requester 2 sends A=16'h00FF, B=16'h0001 with `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_sum`=17'h00100, `rsp_id`=2.
- **Carry out:** A=16'hFFFF, B=16'h0001 → `rsp_sum`=17'h10000 (`Cout`=1, `S`=0). With the macro on and an exact adder, `rsp_err`=0 and `err_count` stays 0.
- **Round-robin:** all 4 requesters valid continuously, `rsp_ready`=1 → `rsp_id` sequence 0,1,2,3,0,… with one result per cycle.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles while requests are pending → `req_ready`=0 and `rsp_sum`/`rsp_id` stable. On release, the held result drains and a new grant occurs in the same cycle.
- **Mismatch counter (macro on):**
  - Force a mismatch by substituting an approximate netlist; apply 3 mismatching operand pairs → `rsp_err`=1 on each, `err_count`=3.
  - Preload near saturation → count holds at 16'hFFFF.
